// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI command words and shares one RAM port with a host; SPI has priority.
// Optional SPI address auto-increment is enabled by defining SPI_RAM_ARB_AUTOINC_EN.
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            spi_rx_data,
    input  logic                  spi_rx_valid,
    output logic [DATA_WIDTH-1:0] spi_tx_data,
    output logic                  spi_tx_valid,
    output logic                  spi_ovf,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACC, RET} state_t;

    state_t                r_state;
    logic                  r_own_spi;
    logic                  r_ram_en;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_host_gnt;
    logic                  r_host_rvalid;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic                  r_ovf;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_pend;
    logic                  r_pend_rd;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [DATA_WIDTH-1:0] r_pend_data;

    logic                  w_data_cmd;
    logic                  w_load_wr;
    logic                  w_load_rd;
    logic                  w_consume;
    logic                  w_inc_wr;
    logic                  w_inc_rd;
    logic [ADDR_WIDTH-1:0] w_payload_addr;

    assign w_data_cmd     = spi_rx_valid && spi_rx_data[8];
    assign w_load_wr      = spi_rx_valid && (spi_rx_data[9:8] == 2'b00);
    assign w_load_rd      = spi_rx_valid && (spi_rx_data[9:8] == 2'b10);
    assign w_consume      = (r_state == IDLE) && r_pend;
    assign w_payload_addr = spi_rx_data[ADDR_WIDTH-1:0];

`ifdef SPI_RAM_ARB_AUTOINC_EN
    assign w_inc_wr = (r_state == ACC) && r_own_spi && r_ram_we;
    assign w_inc_rd = (r_state == ACC) && r_own_spi && !r_ram_we;
`else
    assign w_inc_wr = 1'b0;
    assign w_inc_rd = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else begin
            r_wr_addr <= w_load_wr ? w_payload_addr : (w_inc_wr ? r_wr_addr + 1'b1 : r_wr_addr);
            r_rd_addr <= w_load_rd ? w_payload_addr : (w_inc_rd ? r_rd_addr + 1'b1 : r_rd_addr);
        end
    end

    // A consume in the same cycle as a new data command is not an overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_ovf       <= 1'b0;
        end else if (w_data_cmd) begin
            r_pend      <= 1'b1;
            r_pend_rd   <= spi_rx_data[9];
            r_pend_addr <= spi_rx_data[9] ? r_rd_addr : r_wr_addr;
            r_pend_data <= spi_rx_data[DATA_WIDTH-1:0];
            if (r_pend && !w_consume)
                r_ovf <= 1'b1;
        end else if (w_consume) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_own_spi     <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_host_gnt    <= 1'b0;
            r_host_rvalid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_host_rvalid <= 1'b0;
                    if (r_pend) begin
                        r_state     <= ACC;
                        r_own_spi   <= 1'b1;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= !r_pend_rd;
                        r_ram_addr  <= r_pend_addr;
                        r_ram_wdata <= r_pend_data;
                    end else if (host_req) begin
                        r_state     <= ACC;
                        r_own_spi   <= 1'b0;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= host_we;
                        r_ram_addr  <= host_addr;
                        r_ram_wdata <= host_wdata;
                        r_host_gnt  <= 1'b1;
                    end
                end
                ACC: begin
                    r_ram_en      <= 1'b0;
                    r_ram_we      <= 1'b0;
                    r_host_gnt    <= 1'b0;
                    r_state       <= r_ram_we ? IDLE : RET;
                    r_host_rvalid <= !r_ram_we && !r_own_spi;
                end
                default: begin
                    r_host_rvalid <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    // A read return coinciding with an SPI strobe keeps tx_valid set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else if (r_state == RET && r_own_spi) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= ram_rdata;
        end else if (spi_rx_valid) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign spi_tx_data  = r_tx_data;
    assign spi_tx_valid = r_tx_valid;
    assign spi_ovf      = r_ovf;
    assign host_gnt     = r_host_gnt;
    assign host_rvalid  = r_host_rvalid;
    assign host_rdata   = r_host_rvalid ? ram_rdata : '0;
    assign ram_en       = r_ram_en;
    assign ram_we       = r_ram_we;
    assign ram_addr     = r_ram_addr;
    assign ram_wdata    = r_ram_wdata;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed checks of spi_ram_arbiter against a behavioural single-port RAM.
module tb_spi_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] spi_rx_data = '0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_tx_data;
    logic       spi_tx_valid;
    logic       spi_ovf;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic [7:0] mem [256];
    int         n_cmp = 0;
    int         n_bad = 0;

    spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
        .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_ovf(spi_ovf),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi(input logic [9:0] w);
        spi_rx_data  = w;
        spi_rx_valid = 1'b1;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    function automatic logic [15:0] all_out();
        return {spi_tx_valid, spi_ovf, host_gnt, host_rvalid, ram_en, ram_we,
                |spi_tx_data, |host_rdata, |ram_addr, |ram_wdata};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        tick(3);
        chk("reset_outputs", all_out(), 16'h0);
        rst_n = 1'b1;
        tick();

        // SPI write: 0x005 then 0x1A5
        spi(10'h005);
        spi(10'h1A5);
        tick();
        chk("wr_ram_en", {ram_en, ram_we}, 16'h3);
        chk("wr_ram_addr", ram_addr, 16'h05);
        chk("wr_ram_wdata", ram_wdata, 16'hA5);
        chk("wr_no_ovf", spi_ovf, 16'h0);
        tick();
        chk("wr_ram_en_drop", ram_en, 16'h0);
        chk("wr_mem5", mem[5], 16'hA5);

        // SPI read: 0x205 then 0x300
        spi(10'h205);
        spi(10'h300);
        tick();
        chk("rd_ram_acc", {ram_en, ram_we, ram_addr}, {8'h02, 8'h05});
        tick(2);
        chk("rd_tx_valid", spi_tx_valid, 16'h1);
        chk("rd_tx_data", spi_tx_data, 16'hA5);
        tick(4);
        chk("rd_tx_held", {spi_tx_valid, spi_tx_data}, 16'h1A5);
        spi(10'h000);
        chk("rd_tx_cleared", spi_tx_valid, 16'h0);

        // Host read while SPI write pending: SPI first
        spi(10'h020);
        spi(10'h177);
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        tick();
        chk("arb_spi_first", {host_gnt, ram_en, ram_we, ram_addr}, {8'h03, 8'h20});
        tick();
        chk("arb_gap_no_gnt", host_gnt, 16'h0);
        tick();
        chk("arb_host_gnt", {host_gnt, ram_en, ram_we, ram_addr}, {8'h06, 8'h10});
        host_req = 1'b0;
        tick();
        chk("arb_host_rvalid", {host_rvalid, host_rdata}, 16'h13C);
        chk("arb_mem20", mem[8'h20], 16'h77);
        tick();
        chk("arb_rvalid_pulse", host_rvalid, 16'h0);

        // Overwrite while pending: host keeps the FSM busy
        host_req = 1'b1;
        tick();
        chk("ovf_host_gnt", host_gnt, 16'h1);
        host_req = 1'b0;
        spi(10'h1B1);
        spi(10'h1C2);
        chk("ovf_set", spi_ovf, 16'h1);
        tick();
        chk("ovf_second_written", {ram_en, ram_we, ram_wdata}, 16'h3C2);
        tick(3);
        chk("ovf_sticky", spi_ovf, 16'h1);
        chk("ovf_mem20", mem[8'h20], 16'hC2);

        // Reset during RET of an SPI read
        spi(10'h220);
        spi(10'h300);
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", all_out(), 16'h0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("rst_no_tx_valid", {spi_tx_valid, ram_en}, 16'h0);

        // Address wrap / no-autoinc behaviour
        spi(10'h0FF);
        spi(10'h111);
        tick(3);
        spi(10'h122);
        tick(3);
`ifdef SPI_RAM_ARB_AUTOINC_EN
        chk("inc_memFF", mem[8'hFF], 16'h11);
        chk("inc_mem00", mem[8'h00], 16'h22);
`else
        chk("noinc_memFF", mem[8'hFF], 16'h22);
        chk("noinc_mem00", mem[8'h00], 16'h00);
`endif

        // New data command in the same cycle the pending one is consumed: no ovf
        spi(10'h030);
        spi(10'h144);
        spi(10'h155);
        tick(2);
        chk("samecyc_second_acc", {ram_en, ram_we, ram_addr}, {8'h03, 8'h30});
        chk("samecyc_wdata", ram_wdata, 16'h55);
        chk("samecyc_no_ovf", spi_ovf, 16'h0);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
